alu_cmd_responder: RTL and testbench

- Device-side end of the UART ALU byte protocol.
- Consumes the command byte stream from the `uart` receive AXI-stream output (`m_axis_*`).
- Parses one framed command, executes it, and returns the reply bytes on an AXI-stream master that feeds the `uart` transmit input (`s_axis_*`).
- It is the responder for the host/bench sender that drives `uart_tx` into RX.

---
 rtl/alu_cmd_responder.sv | 203 ++++++++++++++++++++
 tb/tb_alu_cmd_responder.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_responder.sv
// Device-side responder for the UART ALU byte protocol.
// It parses a framed command from the RX byte stream, runs ECHO/ADD/MUL, and streams the reply to TX.
module alu_cmd_responder #(
    parameter logic [7:0] OP_ECHO  = 8'hEC,
    parameter logic [7:0] OP_ADD   = 8'hA0,
    parameter logic [7:0] OP_MUL   = 8'hA1,
    parameter logic [7:0] ERR_BYTE = 8'hEE
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    output logic       s_axis_tready,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    input  logic       m_axis_tready,
    output logic       busy_o,
    output logic       err_o
);

    typedef enum logic [2:0] {
        ST_HDR   = 3'd0,
        ST_ECHO  = 3'd1,
        ST_ACCUM = 3'd2,
        ST_RESP  = 3'd3,
        ST_DRAIN = 3'd4,
        ST_ERR   = 3'd5
    } state_t;

    state_t      state_q;
    logic [1:0]  hdr_cnt_q;
    logic [7:0]  op_q;
    logic [7:0]  len_lo_q;
    logic [15:0] rem_q;
    logic [31:0] acc_q;
    logic [23:0] word_q;
    logic [1:0]  byte_idx_q;
    logic [1:0]  resp_idx_q;
    logic        m_valid_q;
    logic [7:0]  m_data_q;
    logic        err_q;

    logic        s_fire_s;
    logic        m_fire_s;
    logic [15:0] len_s;
    logic [15:0] pay_s;
    logic [31:0] word_s;
    logic [31:0] sum_s;
    logic [31:0] prod_s;
    logic [31:0] acc_new_s;

    assign s_fire_s  = s_axis_tvalid && s_axis_tready;
    assign m_fire_s  = m_valid_q && m_axis_tready;
    assign len_s     = {s_axis_tdata, len_lo_q};
    assign pay_s     = len_s - 16'd4;
    assign word_s    = {s_axis_tdata, word_q};
    assign sum_s     = acc_q + word_s;
    assign prod_s    = acc_q * word_s;
    assign acc_new_s = (op_q == OP_MUL) ? prod_s : sum_s;

    assign busy_o = (state_q != ST_HDR) || (hdr_cnt_q != 2'd0);
    assign err_o  = err_q;

    // Handshake steering: ECHO bypasses the output register so bytes flow straight through.
    always_comb begin
        s_axis_tready = 1'b0;
        m_axis_tvalid = m_valid_q;
        m_axis_tdata  = m_data_q;
        case (state_q)
            ST_HDR, ST_ACCUM, ST_DRAIN: s_axis_tready = 1'b1;
            ST_ECHO: begin
                s_axis_tready = m_axis_tready;
                m_axis_tvalid = s_axis_tvalid;
                m_axis_tdata  = s_axis_tdata;
            end
            default: s_axis_tready = 1'b0;
        endcase
    end

    // Frame parser, accumulator and reply sequencer.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_HDR;
            hdr_cnt_q  <= 2'd0;
            op_q       <= 8'd0;
            len_lo_q   <= 8'd0;
            rem_q      <= 16'd0;
            acc_q      <= 32'd0;
            word_q     <= 24'd0;
            byte_idx_q <= 2'd0;
            resp_idx_q <= 2'd0;
            m_valid_q  <= 1'b0;
            m_data_q   <= 8'd0;
            err_q      <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                ST_HDR: begin
                    if (s_fire_s) begin
                        hdr_cnt_q <= hdr_cnt_q + 2'd1;
                        case (hdr_cnt_q)
                            2'd0: op_q     <= s_axis_tdata;
                            2'd2: len_lo_q <= s_axis_tdata;
                            2'd3: begin
                                if (len_s < 16'd4) begin
                                    state_q   <= ST_ERR;
                                    err_q     <= 1'b1;
                                    m_valid_q <= 1'b1;
                                    m_data_q  <= ERR_BYTE;
                                end else if (op_q == OP_ECHO) begin
                                    // An empty echo frame completes silently.
                                    if (pay_s != 16'd0) begin
                                        state_q <= ST_ECHO;
                                        rem_q   <= pay_s;
                                    end
                                end else if ((op_q == OP_ADD || op_q == OP_MUL) &&
                                             pay_s != 16'd0 && pay_s[1:0] == 2'd0) begin
                                    state_q    <= ST_ACCUM;
                                    rem_q      <= pay_s;
                                    acc_q      <= (op_q == OP_MUL) ? 32'd1 : 32'd0;
                                    byte_idx_q <= 2'd0;
                                end else if (pay_s != 16'd0) begin
                                    state_q <= ST_DRAIN;
                                    rem_q   <= pay_s;
                                end else begin
                                    state_q   <= ST_ERR;
                                    err_q     <= 1'b1;
                                    m_valid_q <= 1'b1;
                                    m_data_q  <= ERR_BYTE;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                ST_ECHO: begin
                    if (s_axis_tvalid && m_axis_tready) begin
                        rem_q <= rem_q - 16'd1;
                        if (rem_q == 16'd1) begin
                            state_q <= ST_HDR;
                        end
                    end
                end
                ST_ACCUM: begin
                    if (s_fire_s) begin
                        rem_q      <= rem_q - 16'd1;
                        byte_idx_q <= byte_idx_q + 2'd1;
                        case (byte_idx_q)
                            2'd0: word_q[7:0]   <= s_axis_tdata;
                            2'd1: word_q[15:8]  <= s_axis_tdata;
                            2'd2: word_q[23:16] <= s_axis_tdata;
                            default: acc_q      <= acc_new_s;
                        endcase
                        // Payload is a whole number of words, so the last byte always closes a word.
                        if (rem_q == 16'd1) begin
                            state_q    <= ST_RESP;
                            resp_idx_q <= 2'd0;
                            m_valid_q  <= 1'b1;
                            m_data_q   <= acc_new_s[7:0];
                        end
                    end
                end
                ST_RESP: begin
                    if (m_fire_s) begin
                        resp_idx_q <= resp_idx_q + 2'd1;
                        case (resp_idx_q)
                            2'd0: m_data_q <= acc_q[15:8];
                            2'd1: m_data_q <= acc_q[23:16];
                            2'd2: m_data_q <= acc_q[31:24];
                            default: begin
                                m_valid_q <= 1'b0;
                                state_q   <= ST_HDR;
                            end
                        endcase
                    end
                end
                ST_DRAIN: begin
                    if (s_fire_s) begin
                        rem_q <= rem_q - 16'd1;
                        if (rem_q == 16'd1) begin
                            state_q   <= ST_ERR;
                            err_q     <= 1'b1;
                            m_valid_q <= 1'b1;
                            m_data_q  <= ERR_BYTE;
                        end
                    end
                end
                ST_ERR: begin
                    if (m_fire_s) begin
                        m_valid_q <= 1'b0;
                        state_q   <= ST_HDR;
                    end
                end
                default: begin
                    state_q   <= ST_HDR;
                    hdr_cnt_q <= 2'd0;
                    m_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_responder.sv
// Self-checking bench for alu_cmd_responder: frame-level reference model plus a reply scoreboard.
module tb_alu_cmd_responder;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic [7:0] s_tdata = 8'd0;
    logic       s_tvalid = 1'b0;
    logic       s_tready;
    logic [7:0] m_tdata;
    logic       m_tvalid;
    logic       m_tready = 1'b1;
    logic       busy_o;
    logic       err_o;

    int n_tests = 0;
    int n_fail = 0;
    int exp_err = 0;
    int seen_err = 0;
    int rdy_mode = 0;
    bit echo_flag = 1'b0;
    bit mon_en = 1'b0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    alu_cmd_responder dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .s_axis_tdata (s_tdata),
        .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready),
        .m_axis_tdata (m_tdata),
        .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready),
        .busy_o       (busy_o),
        .err_o        (err_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Reference: whole-frame semantics of the protocol.
    task automatic model_frame(input logic [7:0] f[$], output logic [7:0] r[$], output bit is_err);
        int len;
        int n;
        logic [31:0] acc;
        logic [31:0] w;
        r = {};
        is_err = 1'b0;
        len = int'({f[3], f[2]});
        n = len - 4;
        if (len < 4) begin
            is_err = 1'b1;
        end else if (f[0] == 8'hEC) begin
            for (int i = 0; i < n; i++) r.push_back(f[4 + i]);
        end else if ((f[0] == 8'hA0 || f[0] == 8'hA1) && n > 0 && n % 4 == 0) begin
            acc = (f[0] == 8'hA1) ? 32'd1 : 32'd0;
            for (int k = 0; k < n / 4; k++) begin
                w = {f[7 + 4*k], f[6 + 4*k], f[5 + 4*k], f[4 + 4*k]};
                acc = (f[0] == 8'hA0) ? acc + w : acc * w;
            end
            for (int j = 0; j < 4; j++) r.push_back(acc[8*j +: 8]);
        end else begin
            is_err = 1'b1;
        end
        if (is_err) r.push_back(8'hEE);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        for (int g = 0; g < gap; g++) begin
            @(posedge clk);
            #1;
        end
        s_tvalid = 1'b1;
        s_tdata  = b;
        n = 0;
        @(negedge clk);
        while (!s_tready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!s_tready) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: byte %02h never accepted, expected acceptance", b);
        end
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] f[$], input bit rand_gap);
        logic [7:0] r[$];
        bit e;
        int len;
        model_frame(f, r, e);
        foreach (r[i]) exp_q.push_back(r[i]);
        if (e) exp_err++;
        len = int'({f[3], f[2]});
        for (int i = 0; i < f.size(); i++) begin
            if (i == 4 && f[0] == 8'hEC && len >= 5) echo_flag = 1'b1;
            send_byte(f[i], rand_gap ? int'($urandom_range(0, 2)) : 0);
        end
        echo_flag = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy_o) && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("idle_reached", {31'd0, (exp_q.size() == 0 && !busy_o)}, 32'd1);
    endtask

    task automatic check_reset_state();
        check("rst_m_tvalid", {31'd0, m_tvalid}, 32'd0);
        check("rst_m_tdata", {24'd0, m_tdata}, 32'd0);
        check("rst_s_tready", {31'd0, s_tready}, 32'd1);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_err", {31'd0, err_o}, 32'd0);
    endtask

    // Sink ready pattern: always, random, or held off.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       m_tready = 1'b1;
                1:       m_tready = ($urandom_range(0, 3) != 0);
                default: m_tready = 1'b0;
            endcase
        end
    end

    // Scoreboard and handshake-rule monitor, sampled mid-cycle.
    initial begin
        logic       prev_stall;
        logic [7:0] prev_data;
        prev_stall = 1'b0;
        prev_data  = 8'd0;
        forever begin
            @(negedge clk);
            if (rst_i || !mon_en) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("hold_valid", {31'd0, m_tvalid}, 32'd1);
                    check("hold_data", {24'd0, m_tdata}, {24'd0, prev_data});
                end
                if (echo_flag) check("echo_ready", {31'd0, s_tready}, {31'd0, m_tready});
                if (err_o) seen_err++;
                if (m_tvalid && m_tready) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_byte: got %02h, expected no byte", m_tdata);
                    end else begin
                        check("reply_byte", {24'd0, m_tdata}, {24'd0, exp_q.pop_front()});
                    end
                end
                prev_stall = m_tvalid && !m_tready;
                prev_data  = m_tdata;
            end
        end
    end

    initial begin
        logic [7:0] fr[$];
        logic [7:0] r[$];
        bit e;
        int len;
        int n;
        logic [7:0] op;

        repeat (3) @(posedge clk);
        #1;
        rst_i = 1'b0;
        check_reset_state();
        mon_en = 1'b1;

        fr = '{8'hA1, 8'h00, 8'h0C, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h00, 8'h00, 8'h00};
        model_frame(fr, r, e);
        check("model_mul", {r[3], r[2], r[1], r[0]}, 32'hFFFF_FFFE);
        fr = '{8'hEC, 8'h00, 8'h06, 8'h00, 8'h11, 8'h22};
        model_frame(fr, r, e);
        check("model_echo", {16'd0, r[1], r[0]}, 32'h0000_2211);
        fr = '{8'hA0, 8'h00, 8'h07, 8'h00, 8'h01, 8'h02, 8'h03};
        model_frame(fr, r, e);
        check("model_err", {23'd0, e, r[0]}, 32'h0000_01EE);

        fr = '{8'hEC, 8'h00, 8'h06, 8'h00, 8'h11, 8'h22};
        send_frame(fr, 1'b0);
        wait_idle();
        check("echo_busy_after", {31'd0, busy_o}, 32'd0);
        check("echo_no_err", seen_err, 32'd0);

        fr = '{8'hA0, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
        send_frame(fr, 1'b0);
        check("add_first_valid", {31'd0, m_tvalid}, 32'd1);
        check("add_first_data", {24'd0, m_tdata}, 32'h03);
        wait_idle();

        fr = '{8'hA1, 8'h00, 8'h0C, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h00, 8'h00, 8'h00};
        send_frame(fr, 1'b0);
        wait_idle();

        fr = '{8'h55, 8'h00, 8'h06, 8'h00, 8'hAA, 8'hBB};
        send_frame(fr, 1'b0);
        wait_idle();
        check("bad_op_err_count", seen_err, 32'd1);
        fr = '{8'hA0, 8'h00, 8'h07, 8'h00, 8'h01, 8'h02, 8'h03};
        send_frame(fr, 1'b0);
        wait_idle();
        fr = '{8'h11, 8'h00, 8'h02, 8'h00};
        send_frame(fr, 1'b0);
        check("short_len_valid", {31'd0, m_tvalid}, 32'd1);
        check("short_len_data", {24'd0, m_tdata}, 32'hEE);
        check("short_len_err", {31'd0, err_o}, 32'd1);
        wait_idle();

        rdy_mode = 2;
        fr = '{8'hA0, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
        send_frame(fr, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        check("bp_add_valid", {31'd0, m_tvalid}, 32'd1);
        check("bp_add_data", {24'd0, m_tdata}, 32'h03);
        rdy_mode = 0;
        wait_idle();
        rdy_mode = 2;
        fr = '{8'hEC, 8'h00, 8'h08, 8'h00, 8'h31, 8'h32, 8'h33, 8'h34};
        fork
            send_frame(fr, 1'b0);
            begin
                repeat (12) @(posedge clk);
                rdy_mode = 0;
            end
        join
        wait_idle();

        rdy_mode = 1;
        for (int f = 0; f < 60; f++) begin
            case ($urandom_range(0, 3))
                0:       op = 8'hEC;
                1:       op = 8'hA0;
                2:       op = 8'hA1;
                default: op = 8'($urandom_range(0, 255));
            endcase
            if ($urandom_range(0, 9) == 0) begin
                len = int'($urandom_range(0, 3));
                n = 0;
            end else begin
                n = ($urandom_range(0, 2) != 0) ? 4 * int'($urandom_range(1, 3)) : int'($urandom_range(0, 9));
                len = n + 4;
            end
            fr = '{op, 8'($urandom_range(0, 255)), 8'(len), 8'(len >> 8)};
            for (int i = 0; i < n; i++) fr.push_back(8'($urandom_range(0, 255)));
            send_frame(fr, 1'b1);
        end
        wait_idle();

        rdy_mode = 0;
        fr = '{8'hA0, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h02};
        foreach (fr[i]) send_byte(fr[i], 0);
        rst_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b0;
        check_reset_state();
        fr = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'h5A};
        send_frame(fr, 1'b0);
        wait_idle();
        repeat (5) @(posedge clk);
        #1;

        check("err_count", seen_err, exp_err);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
